// File: rtl/gbt_tx_clk_pkg.sv
// Shared types and defaults for the GBT TX frame-clock PLL sequencer.
// Holds the FSM state type, the default cycle counts and the retry counter width.
package gbt_tx_clk_pkg;

    typedef enum logic [1:0] {
        PLL_RST     = 2'd0,
        WAIT_LOCK   = 2'd1,
        STABLE_WAIT = 2'd2,
        READY       = 2'd3
    } seq_state_t;

    localparam int DEF_PLL_RST_CYCLES  = 16;
    localparam int DEF_LOCK_TIMEOUT    = 1024;
    localparam int DEF_STABLE_CYCLES   = 256;
    localparam int DEF_WORDS_PER_FRAME = 3;

    localparam int RETRY_W = 8;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    // Width of the shared down-counter; it only ever holds values up to max-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/gbt_bit_sync.sv
// Multi-stage flop synchronizer for a single asynchronous level signal.
// All stages clear on reset, so the output reads 0 until the input has propagated through them.
module gbt_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) stage_reg[gi] <= 1'b0;
                    else     stage_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) stage_reg[gi] <= 1'b0;
                    else     stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/gbt_tx_frameclk_seq.sv
// TX frame-clock PLL bring-up sequencer: resets the PLL, waits for a stable lock,
// then runs the word-within-frame counter and retries on timeouts or lock losses.
module gbt_tx_frameclk_seq
    import gbt_tx_clk_pkg::*;
#(
    parameter int PLL_RST_CYCLES  = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int WORDS_PER_FRAME = DEF_WORDS_PER_FRAME
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               tx_ready,
    output logic               frame_strobe,
    output logic [1:0]         word_idx,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       WORD_LAST   = 2'(WORDS_PER_FRAME - 1);

    logic               locked_s;
    seq_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [1:0]         word_reg, word_next;
    logic               retry_inc;
    logic               pll_rst_reg, tx_ready_reg, strobe_reg;

    gbt_bit_sync #(
        .STAGES (2)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_inc  = 1'b0;
        case (state_reg)
            PLL_RST: begin
                if (cnt_reg == '0) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = TO_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABLE_WAIT;
                    cnt_next   = STABLE_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = PLL_RST;
                    cnt_next   = RST_LOAD;
                    retry_inc  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            STABLE_WAIT: begin
                // A dropout here only restarts the lock wait; it is not counted as a retry.
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = TO_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            READY: begin
                if (!locked_s) begin
                    state_next = PLL_RST;
                    cnt_next   = RST_LOAD;
                    retry_inc  = 1'b1;
                end
            end
            default: begin
                state_next = PLL_RST;
                cnt_next   = RST_LOAD;
            end
        endcase

        retry_next = (retry_inc && (retry_reg != RETRY_MAX)) ? retry_reg + RETRY_W'(1) : retry_reg;

        word_next = 2'd0;
        if (state_next == READY && state_reg == READY) begin
            word_next = (word_reg == WORD_LAST) ? 2'd0 : word_reg + 2'd1;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg    <= PLL_RST;
            cnt_reg      <= RST_LOAD;
            retry_reg    <= '0;
            word_reg     <= 2'd0;
            pll_rst_reg  <= 1'b1;
            tx_ready_reg <= 1'b0;
            strobe_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            retry_reg    <= retry_next;
            word_reg     <= word_next;
            pll_rst_reg  <= (state_next == PLL_RST);
            tx_ready_reg <= (state_next == READY);
            strobe_reg   <= (state_next == READY) && (word_next == 2'd0);
        end
    end

    assign pll_rst      = pll_rst_reg;
    assign tx_ready     = tx_ready_reg;
    assign frame_strobe = strobe_reg;
    assign word_idx     = word_reg;
    assign retry_cnt    = retry_reg;

endmodule

// File: tb/tb_gbt_tx_frameclk_seq.sv
// Scoreboard bench for the TX frame-clock sequencer: a phase/elapsed-time model predicts
// every cycle's outputs into a queue, and a negedge monitor pops and compares them.
module tb_gbt_tx_frameclk_seq;

    localparam int P_RST = 16;
    localparam int P_TO  = 1024;
    localparam int P_ST  = 128;
    localparam int WPF   = 3;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_READY  = 3;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       tx_ready;
    logic       frame_strobe;
    logic [1:0] word_idx;
    logic [7:0] retry_cnt;

    typedef struct {
        int         cyc;
        logic       pll_rst;
        logic       tx_ready;
        logic       strobe;
        logic [1:0] word;
        logic [7:0] retry;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   m_phase = PH_RST;
    int   m_el = 0;
    int   m_retry = 0;
    int   m_cyc = 0;
    int   m_rstart = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;

    gbt_tx_frameclk_seq #(
        .PLL_RST_CYCLES  (P_RST),
        .LOCK_TIMEOUT    (P_TO),
        .STABLE_CYCLES   (P_ST),
        .WORDS_PER_FRAME (WPF)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .tx_ready     (tx_ready),
        .frame_strobe (frame_strobe),
        .word_idx     (word_idx),
        .retry_cnt    (retry_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    function automatic int m_word();
        return (m_phase == PH_READY) ? ((m_cyc - m_rstart) % WPF) : 0;
    endfunction

    // Apply one cycle of inputs, advance the reference model over that edge, queue the prediction.
    task automatic step(input logic r, input logic l);
        exp_t e;
        logic ls;
        rst        = r;
        pll_locked = l;
        @(posedge refclk);
        m_cyc++;
        if (r) begin
            m_phase = PH_RST;
            m_el    = 0;
            m_retry = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = l;
            case (m_phase)
                PH_RST: begin
                    if (m_el == P_RST - 1) begin m_phase = PH_WAIT; m_el = 0; end
                    else m_el++;
                end
                PH_WAIT: begin
                    if (ls) begin m_phase = PH_STABLE; m_el = 0; end
                    else if (m_el == P_TO - 1) begin
                        m_phase = PH_RST; m_el = 0;
                        if (m_retry < 255) m_retry++;
                    end else m_el++;
                end
                PH_STABLE: begin
                    if (!ls) begin m_phase = PH_WAIT; m_el = 0; end
                    else if (m_el == P_ST - 1) begin m_phase = PH_READY; m_rstart = m_cyc; end
                    else m_el++;
                end
                default: begin
                    if (!ls) begin
                        m_phase = PH_RST; m_el = 0;
                        if (m_retry < 255) m_retry++;
                    end
                end
            endcase
        end
        e.cyc      = m_cyc;
        e.pll_rst  = (m_phase == PH_RST);
        e.tx_ready = (m_phase == PH_READY);
        e.word     = 2'(m_word());
        e.strobe   = (m_phase == PH_READY) && (m_word() == 0);
        e.retry    = 8'(m_retry);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic wait_ready(input bit want, input string what);
        int n;
        n = 0;
        while (((m_phase == PH_READY) != want) && n < 3000) begin
            step(1'b0, 1'b1);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: waited %0d cycles, required below 3000", what, n);
        end
    endtask

    always @(negedge refclk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pll_rst !== e.pll_rst || tx_ready !== e.tx_ready || frame_strobe !== e.strobe ||
                word_idx !== e.word || retry_cnt !== e.retry) begin
                errors++;
                $display("FAIL cycle %0d outputs: got pll_rst=%b tx_ready=%b frame_strobe=%b word_idx=%0d retry_cnt=%0d, want %b %b %b %0d %0d",
                         e.cyc, pll_rst, tx_ready, frame_strobe, word_idx, retry_cnt,
                         e.pll_rst, e.tx_ready, e.strobe, e.word, e.retry);
            end
        end
    end

    initial begin
        int n;
        logic lvl;
        rst        = 1'b1;
        pll_locked = 1'b0;

        $display("scenario reset release with lock held");
        repeat (3) step(1'b1, 1'b1);
        repeat (P_RST + P_ST + 40) step(1'b0, 1'b1);

        $display("scenario one-cycle lock drop in READY");
        step(1'b0, 1'b0);
        repeat (P_RST + P_ST + 40) step(1'b0, 1'b1);

        $display("scenario reset pulse at word_idx 2");
        n = 0;
        while (!(m_phase == PH_READY && m_word() == 2) && n < 50) begin
            step(1'b0, 1'b1);
            n++;
        end
        step(1'b1, 1'b1);
        repeat (P_RST + P_ST + 30) step(1'b0, 1'b1);

        $display("scenario glitch at STABLE_WAIT cycle 100");
        step(1'b1, 1'b1);
        n = 0;
        while (!(m_phase == PH_STABLE && m_el == 100) && n < 3000) begin
            step(1'b0, 1'b1);
            n++;
        end
        step(1'b0, 1'b0);
        repeat (P_ST + 60) step(1'b0, 1'b1);

        $display("scenario lock never arrives");
        step(1'b1, 1'b0);
        repeat (3 * (P_RST + P_TO) + 50) step(1'b0, 1'b0);

        $display("scenario randomized lock/reset activity");
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: step(1'b1, 1'($urandom_range(0, 1)));
                1: repeat ($urandom_range(1, 4)) step(1'b0, 1'b0);
                default: begin
                    lvl = ($urandom_range(0, 3) != 0);
                    repeat ($urandom_range(20, 400)) step(1'b0, lvl);
                end
            endcase
        end

        $display("scenario 300 forced lock losses");
        step(1'b1, 1'b1);
        for (int k = 0; k < 300; k++) begin
            wait_ready(1'b1, "reach READY");
            step(1'b0, 1'b0);
            wait_ready(1'b0, "leave READY");
        end
        repeat (20) step(1'b0, 1'b1);

        repeat (2) @(negedge refclk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
